reduce_seq_pipe: RTL and testbench

Pipelined, parameterised successor to the combinational N-input AND chain. Reduces an N-bit vector to one bit with a per-transaction operator (AND, OR, XOR, NAND). The work is spread over `STAGES` registered stages of `CHUNK` bits each, behind a valid/ready handshake with full backpressure. It sits between a vector producer and a single-bit consumer in the basic-gate fixture family, and is the sequential reference target for matching chained reductions.

---
 rtl/reduce_pkg.sv | 53 +++++
 rtl/reduce_seq_pipe_if.sv | 26 ++
 rtl/reduce_stage.sv | 68 ++++++
 rtl/reduce_seq_pipe.sv | 96 +++++++++
 tb/tb_reduce_seq_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reduce_pkg.sv
// Shared types and helpers for the pipelined vector reduction.
// Mode encoding, identity/combine operators, per-stage width helpers.
package reduce_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_AND  = 2'b00;
    localparam mode_t MODE_OR   = 2'b01;
    localparam mode_t MODE_XOR  = 2'b10;
    localparam mode_t MODE_NAND = 2'b11;

    // Neutral element: 1 for AND/NAND, 0 for OR/XOR.
    function automatic logic identity(input mode_t mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

    // NAND accumulates as AND; inversion happens once at the output.
    function automatic logic combine(
        input mode_t mode,
        input logic  a,
        input logic  b
    );
        logic r;
        unique case (mode)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_XOR:  r = a ^ b;
            MODE_NAND: r = a & b;
        endcase
        return r;
    endfunction

    // Bits still unconsumed when entering stage idx.
    function automatic int in_w(int n, int chunk, int idx);
        return n - idx * chunk;
    endfunction

    // Bits actually reduced by stage idx (last chunk may be short).
    function automatic int chunk_w(int n, int chunk, int idx);
        return (in_w(n, chunk, idx) < chunk) ? in_w(n, chunk, idx) : chunk;
    endfunction

    // Bits handed on to the next stage (0 for the last stage).
    function automatic int rem_w(int n, int chunk, int idx);
        return in_w(n, chunk, idx) - chunk_w(n, chunk, idx);
    endfunction

    // Storage width for the remaining bits, never zero.
    function automatic int store_w(int n, int chunk, int idx);
        return (rem_w(n, chunk, idx) > 0) ? rem_w(n, chunk, idx) : 1;
    endfunction

endpackage

// File: rtl/reduce_seq_pipe_if.sv
// Producer/consumer handshake bundle for reduce_seq_pipe.
// slave: block side (takes x/mode, drives y); master: environment side.
interface reduce_seq_pipe_if #(
    parameter int N = 8
);
    import reduce_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] x;
    mode_t        mode;
    logic         out_valid;
    logic         out_ready;
    logic         y;

    modport slave (
        input  in_valid, x, mode, out_ready,
        output in_ready, out_valid, y
    );

    modport master (
        output in_valid, x, mode, out_ready,
        input  in_ready, out_valid, y
    );

endinterface

// File: rtl/reduce_stage.sv
// One register slice of the reduction pipeline: reduces chunk IDX.
// Ports: pv/pm/pa/pb from predecessor, nrdy from successor; rdy/vld/md/acc/rem out.
module reduce_stage
    import reduce_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int CHUNK = 2,
    parameter  int IDX   = 0,
    localparam int IW    = in_w(N, CHUNK, IDX),
    localparam int CW    = chunk_w(N, CHUNK, IDX),
    localparam int RW    = rem_w(N, CHUNK, IDX),
    localparam int SW    = store_w(N, CHUNK, IDX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pv,
    input  mode_t         pm,
    input  logic          pa,
    input  logic [0:IW-1] pb,
    input  logic          nrdy,
    output logic          rdy,
    output logic          vld,
    output mode_t         md,
    output logic          acc,
    output logic [0:SW-1] rem
);

    logic red;
    logic nxt;

    // Starting from the identity makes a short chunk behave as padded.
    always_comb begin
        red = identity(pm);
        for (int i = 0; i < CW; i++) begin
            red = combine(pm, red, pb[i]);
        end
        nxt = combine(pm, pa, red);
    end

    assign rdy = !vld || nrdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            md  <= MODE_AND;
            acc <= 1'b0;
        end else if (rdy) begin
            vld <= pv;
            if (pv) begin
                md  <= pm;
                acc <= nxt;
            end
        end
    end

    if (RW > 0) begin : g_rem
        always_ff @(posedge clk) begin
            if (rst) begin
                rem <= '0;
            end else if (rdy && pv) begin
                rem <= pb[CW:IW-1];
            end
        end
    end else begin : g_norem
        assign rem = '0;
    end

endmodule

// File: rtl/reduce_seq_pipe.sv
// Pipelined N-bit AND/OR/XOR/NAND reduction, CHUNK bits per stage.
// Ports: clk, rst (sync, high), bus (slave handshake), inflight (occupancy).
module reduce_seq_pipe
    import reduce_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int CHUNK  = 2,
    localparam int STAGES = (N + CHUNK - 1) / CHUNK,
    localparam int IFW    = $clog2(STAGES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    reduce_seq_pipe_if.slave   bus,
    output logic [IFW-1:0]     inflight
);

    localparam int L = STAGES - 1;

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int IW = in_w(N, CHUNK, s);
        localparam int SW = store_w(N, CHUNK, s);

        logic          pv;
        mode_t         pm;
        logic          pa;
        logic [0:IW-1] pb;
        logic          nrdy;
        logic          rdy;
        logic          vld;
        mode_t         md;
        logic          acc;
        logic [0:SW-1] rem;

        if (s == 0) begin : g_head
            assign pv = bus.in_valid;
            assign pm = bus.mode;
            assign pa = identity(bus.mode);
            assign pb = bus.x;
        end else begin : g_body
            assign pv = g_st[s-1].vld;
            assign pm = g_st[s-1].md;
            assign pa = g_st[s-1].acc;
            assign pb = g_st[s-1].rem;
        end

        if (s == L) begin : g_tail
            // Last stage has no bits left to pass on.
            logic unused_rem;
            assign unused_rem = ^rem;
            assign nrdy = bus.out_ready;
        end else begin : g_link
            assign nrdy = g_st[s+1].rdy;
        end

        reduce_stage #(
            .N     (N),
            .CHUNK (CHUNK),
            .IDX   (s)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .pv   (pv),
            .pm   (pm),
            .pa   (pa),
            .pb   (pb),
            .nrdy (nrdy),
            .rdy  (rdy),
            .vld  (vld),
            .md   (md),
            .acc  (acc),
            .rem  (rem)
        );
    end

    assign bus.in_ready  = g_st[0].rdy;
    assign bus.out_valid = g_st[L].vld;
    assign bus.y = (g_st[L].md == MODE_NAND) ? ~g_st[L].acc
                                             : g_st[L].acc;

    logic tin;
    logic tout;

    assign tin  = bus.in_valid && bus.in_ready;
    assign tout = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (tin && !tout) begin
            inflight <= inflight + 1'b1;
        end else if (!tin && tout) begin
            inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: tb/tb_reduce_seq_pipe.sv
// Self-checking bench for reduce_seq_pipe (N=8/CHUNK=2 and N=5/CHUNK=2).
// Ports: drives both DUTs through reduce_seq_pipe_if master side.
module tb_reduce_seq_pipe;
    import reduce_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] inf8;
    logic [1:0] inf5;
    int         total = 0;
    int         bad = 0;

    reduce_seq_pipe_if #(.N(8)) a ();
    reduce_seq_pipe_if #(.N(5)) b ();

    reduce_seq_pipe #(.N(8), .CHUNK(2)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .bus      (a.slave),
        .inflight (inf8)
    );

    reduce_seq_pipe #(.N(5), .CHUNK(2)) dut5 (
        .clk      (clk),
        .rst      (rst),
        .bus      (b.slave),
        .inflight (inf5)
    );

    always #5 clk = ~clk;

    // Reference: result depends only on how many low n bits are set.
    function automatic logic ref_red(
        input logic [7:0] v,
        input int         n,
        input mode_t      m
    );
        int ones;
        ones = $countones(v & 8'((1 << n) - 1));
        case (m)
            MODE_AND: return ones == n;
            MODE_OR:  return ones != 0;
            MODE_XOR: return ones[0];
            default:  return ones != n;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put8(
        input logic       v,
        input logic [7:0] xv,
        input mode_t      m,
        input logic       r
    );
        a.in_valid  = v;
        a.x         = xv;
        a.mode      = m;
        a.out_ready = r;
        #1;
    endtask

    task automatic put5(
        input logic       v,
        input logic [4:0] xv,
        input mode_t      m,
        input logic       r
    );
        b.in_valid  = v;
        b.x         = xv;
        b.mode      = m;
        b.out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        put8(1'b0, 8'h00, MODE_AND, 1'b0);
        put5(1'b0, 5'h00, MODE_AND, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        tick();
        total++;
        if (a.out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_out_valid got=%b want=0", a.out_valid);
        end
        total++;
        if (a.y !== 1'b0) begin
            bad++; $display("FAIL rst_y got=%b want=0", a.y);
        end
        total++;
        if (inf8 !== 3'd0) begin
            bad++; $display("FAIL rst_inflight got=%0d want=0", inf8);
        end
        total++;
        if (a.in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_ready got=%b want=1", a.in_ready);
        end
        total++;
        if (b.out_valid !== 1'b0 || b.y !== 1'b0 || inf5 !== 2'd0
            || b.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_n5 got=%b%b%0d%b want=0001",
                     b.out_valid, b.y, inf5, b.in_ready);
        end
    endtask

    task automatic test_stream();
        logic [7:0] xs[4] = '{8'hFF, 8'hFE, 8'h00, 8'h80};
        mode_t      ms[4] = '{MODE_AND, MODE_AND, MODE_OR, MODE_XOR};
        logic       ex[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            put8(1'b1, xs[k], ms[k], 1'b1);
            total++;
            if (a.in_ready !== 1'b1) begin
                bad++; $display("FAIL stream_in_ready k=%0d got=%b want=1", k, a.in_ready);
            end
            tick();
            if (k < 3) begin
                total++;
                if (a.out_valid !== 1'b0) begin
                    bad++; $display("FAIL stream_early k=%0d got=%b want=0", k, a.out_valid);
                end
            end
        end
        put8(1'b0, 8'h00, MODE_AND, 1'b1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a.out_valid !== 1'b1 || a.y !== ex[k]) begin
                bad++;
                $display("FAIL stream_out k=%0d got=v%b y%b want=v1 y%b",
                         k, a.out_valid, a.y, ex[k]);
            end
            tick();
        end
        total++;
        if (a.out_valid !== 1'b0) begin
            bad++; $display("FAIL stream_drain got=%b want=0", a.out_valid);
        end
    endtask

    task automatic test_full();
        logic [7:0] xv[5];
        mode_t      mv[5];
        logic       e[5];
        for (int k = 0; k < 5; k++) begin
            xv[k] = 8'($urandom);
            mv[k] = mode_t'($urandom_range(3));
            e[k]  = ref_red(xv[k], 8, mv[k]);
        end
        for (int k = 0; k < 4; k++) begin
            put8(1'b1, xv[k], mv[k], 1'b0);
            total++;
            if (a.in_ready !== 1'b1) begin
                bad++; $display("FAIL fill_in_ready k=%0d got=%b want=1", k, a.in_ready);
            end
            tick();
        end
        put8(1'b1, xv[4], mv[4], 1'b0);
        for (int h = 0; h < 3; h++) begin
            total++;
            if (inf8 !== 3'd4 || a.in_ready !== 1'b0 || a.out_valid !== 1'b1
                || a.y !== e[0]) begin
                bad++;
                $display("FAIL full_hold h=%0d got=inf%0d rdy%b v%b y%b want=inf4 rdy0 v1 y%b",
                         h, inf8, a.in_ready, a.out_valid, a.y, e[0]);
            end
            tick();
        end
        a.out_ready = 1'b1;
        #1;
        total++;
        if (a.in_ready !== 1'b1) begin
            bad++; $display("FAIL full_release_ready got=%b want=1", a.in_ready);
        end
        tick();
        total++;
        if (inf8 !== 3'd4 || a.y !== e[1] || a.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_swap got=inf%0d v%b y%b want=inf4 v1 y%b",
                     inf8, a.out_valid, a.y, e[1]);
        end
        put8(1'b0, 8'h00, MODE_AND, 1'b1);
        for (int k = 2; k < 5; k++) begin
            tick();
            total++;
            if (a.out_valid !== 1'b1 || a.y !== e[k]) begin
                bad++;
                $display("FAIL full_drain k=%0d got=v%b y%b want=v1 y%b",
                         k, a.out_valid, a.y, e[k]);
            end
        end
        tick();
        total++;
        if (a.out_valid !== 1'b0 || inf8 !== 3'd0) begin
            bad++;
            $display("FAIL full_empty got=v%b inf%0d want=v0 inf0", a.out_valid, inf8);
        end
    endtask

    task automatic test_pad();
        logic [4:0] xs[3] = '{5'b11111, 5'b00000, 5'b00001};
        mode_t      ms[3] = '{MODE_NAND, MODE_OR, MODE_XOR};
        logic       ex[3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            put5(1'b1, xs[k], ms[k], 1'b1);
            tick();
        end
        put5(1'b0, 5'h00, MODE_AND, 1'b1);
        total++;
        if (inf5 !== 2'd3) begin
            bad++; $display("FAIL pad_inflight got=%0d want=3", inf5);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (b.out_valid !== 1'b1 || b.y !== ex[k]) begin
                bad++;
                $display("FAIL pad_out k=%0d got=v%b y%b want=v1 y%b",
                         k, b.out_valid, b.y, ex[k]);
            end
            tick();
        end
        total++;
        if (b.out_valid !== 1'b0) begin
            bad++; $display("FAIL pad_drain got=%b want=0", b.out_valid);
        end
    endtask

    task automatic test_midreset();
        logic seen = 1'b0;
        put8(1'b1, 8'hFF, MODE_AND, 1'b1);
        tick();
        put8(1'b1, 8'h01, MODE_OR, 1'b1);
        tick();
        total++;
        if (inf8 !== 3'd2) begin
            bad++; $display("FAIL mid_pre got=%0d want=2", inf8);
        end
        put8(1'b1, 8'hFF, MODE_AND, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (inf8 !== 3'd0 || a.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_after got=inf%0d v%b want=inf0 v0", inf8, a.out_valid);
        end
        put8(1'b0, 8'h00, MODE_AND, 1'b1);
        for (int c = 0; c < 6; c++) begin
            if (a.out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL mid_ghost got=%b want=0", seen);
        end
        put8(1'b1, 8'h7F, MODE_NAND, 1'b1);
        tick();
        put8(1'b0, 8'h00, MODE_AND, 1'b1);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (a.out_valid !== 1'b0) begin
                bad++; $display("FAIL mid_lat k=%0d got=%b want=0", k, a.out_valid);
            end
            tick();
        end
        total++;
        if (a.out_valid !== 1'b1 || a.y !== 1'b1) begin
            bad++;
            $display("FAIL mid_out got=v%b y%b want=v1 y1", a.out_valid, a.y);
        end
        tick();
    endtask

    task automatic test_random();
        logic       q[$];
        logic       pend = 1'b0;
        logic [7:0] px = 8'h00;
        mode_t      pm = MODE_AND;
        logic       e;
        int         sent = 0;
        int         got = 0;
        int         cyc = 0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            if (!pend && sent < 1000 && $urandom_range(3) != 0) begin
                pend = 1'b1;
                px   = 8'($urandom);
                pm   = mode_t'($urandom_range(3));
            end
            put8(pend, px, pm, cyc[0]);
            if (a.out_valid && a.out_ready) begin
                got++;
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_extra got=%b want=none", a.y);
                end else begin
                    e = q.pop_front();
                    if (a.y !== e) begin
                        bad++; $display("FAIL rand_y n=%0d got=%b want=%b", got, a.y, e);
                    end
                end
            end
            if (a.in_valid && a.in_ready) begin
                q.push_back(ref_red(px, 8, pm));
                sent++;
                pend = 1'b0;
            end
            tick();
            cyc++;
            total++;
            if (inf8 !== 3'(q.size())) begin
                bad++;
                $display("FAIL rand_inflight c=%0d got=%0d want=%0d", cyc, inf8, q.size());
            end
        end
        total++;
        if (got != 1000 || q.size() != 0) begin
            bad++;
            $display("FAIL rand_count got=%0d left=%0d want=1000 left=0", got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_pad();
        test_midreset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
